fetch_queue: RTL

//  Decoupling FIFO between the fetch stage and decode. Captures each valid fetched

---
 rtl/fetch_queue.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: a circular buffer with valid/ready
// drain, stall back to fetch when full, and flush on taken branches.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                instr_i,
  input  logic [31:0]                kanata_id_i,
  input  logic                       xcpt_missaligned_i,
  output logic                       stall_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [31:0]                pc_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                kanata_id_o,
  output logic                       xcpt_missaligned_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] id;
    logic        xcpt;
  } entry_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_deq;
  entry_t          w_head;
  entry_t          w_new;

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);

  // Full refuses enqueue even when a dequeue frees a slot this cycle.
  assign w_enq = valid_i & ~w_full & ~flush_i;
  assign w_deq = ~w_empty & ready_i & ~flush_i;

  assign w_new = '{
    pc:    pc_i,
    instr: instr_i,
    id:    kanata_id_i,
    xcpt:  xcpt_missaligned_i
  };

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the count alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_new;
  end

  assign w_head = r_mem[r_rd_ptr];

  assign stall_o            = w_full;
  assign valid_o            = ~w_empty;
  assign count_o            = r_count;
  assign pc_o               = w_head.pc;
  assign kanata_id_o        = w_head.id;
  assign xcpt_missaligned_o = w_head.xcpt;
  assign instr_o            = w_head.xcpt ? NOP_INSTR
                                          : w_head.instr;

endmodule
